// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the programmable clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int RATIO_MIN = 2;

    // High-phase length: ceil(r/2), so odd ratios get the extra cycle high.
    function automatic logic [31:0] high_len(input logic [31:0] r);
        return (r + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_period.sv
// rtl/clk_div_period.sv - period counter, divided-clock flop and boundary decode
module clk_div_period
    import clk_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] ratio,
    input  logic         run,
    input  logic         restart,
    output logic         o_clk,
    output logic         o_tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] h;

    assign cnt_inc = cnt_q + W'(1);
    assign h       = W'(high_len(32'(ratio)));
    assign o_tick  = run && (cnt_q == ratio - W'(1));

    // The last cycle of a period is always low, so stopping at the boundary never cuts a high phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            o_clk <= 1'b0;
        end else if (restart) begin
            cnt_q <= '0;
            o_clk <= 1'b1;
        end else if (o_tick) begin
            cnt_q <= '0;
            o_clk <= 1'b0;
        end else if (run) begin
            cnt_q <= cnt_inc;
            o_clk <= (cnt_inc < h);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop FSM, ratio handshake and glitch-free switchover
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W             = 8,
    parameter int DEFAULT_RATIO = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_ratio,
    output logic         o_cfg_ready,
    output logic         o_cfg_err,
    output logic         o_clk,
    output logic         o_tick,
    output logic [W-1:0] o_ratio,
    output logic         o_active
);

    state_t       state_q, state_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] pend_q, pend_d;
    logic         err_q;
    logic         tick;
    logic         run;
    logic         restart;
    logic         accept;
    logic         legal;
    logic         take;

    assign o_cfg_ready = (state_q != PEND);
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign legal       = (i_cfg_ratio >= W'(RATIO_MIN));
    assign take        = accept && legal;
    assign run         = (state_q != OFF);
    assign restart     = i_en && ((state_q == OFF) || tick);

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        case (state_q)
            OFF: begin
                if (take)
                    ratio_d = i_cfg_ratio;
                if (i_en)
                    state_d = RUN;
            end
            RUN, PEND: begin
                if (tick) begin
                    // A request landing exactly on the boundary wins over any older pending one.
                    if (take)
                        ratio_d = i_cfg_ratio;
                    else if (state_q == PEND)
                        ratio_d = pend_q;
                    state_d = i_en ? RUN : OFF;
                end else if ((state_q == RUN) && take) begin
                    pend_d  = i_cfg_ratio;
                    state_d = PEND;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= OFF;
            ratio_q <= W'(DEFAULT_RATIO);
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            err_q   <= accept && !legal;
        end
    end

    clk_div_period #(
        .W(W)
    ) u_period (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .ratio   (ratio_q),
        .run     (run),
        .restart (restart),
        .o_clk   (o_clk),
        .o_tick  (tick)
    );

    assign o_tick    = tick;
    assign o_cfg_err = err_q;
    assign o_ratio   = ratio_q;
    assign o_active  = run;

endmodule
